// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the N x N matrix-multiply datapath: loads A then B into buffers,
// walks the k-loop on the shared MAC, and hands each C element out on valid/ready.
module matmul_seq_ctrl #(
  parameter int elementsNum = 2,
  parameter int dataWidth   = 16,
  localparam int AW = (elementsNum * elementsNum > 1) ? $clog2(elementsNum * elementsNum) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready_in,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic          acc_en,
  output logic          acc_clr,
  input  logic          ready_out,
  output logic          valid_out,
  output logic          last,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshakes: an input beat is taken when valid_in & ready_in are high on a rising
  // edge; a result is consumed when valid_out & ready_out are high on a rising edge.
  // valid_out and the accumulator stay stable until that edge.

  localparam int IW = (elementsNum > 1) ? $clog2(elementsNum) : 1;
  localparam logic [AW-1:0] LAST_W = AW'(elementsNum * elementsNum - 1);
  localparam logic [IW-1:0] LAST_I = IW'(elementsNum - 1);

  if (elementsNum < 1 || dataWidth < 1) begin : g_bad_cfg
    $error("matmul_seq_ctrl: elementsNum and dataWidth must be >= 1");
  end

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_COMPUTE = 3'd2,
    S_FLUSH   = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wcnt;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic          r_acc_en;
  logic          r_acc_clr;
  logic          w_beat;
  logic          w_last_elem;

  assign w_beat      = valid_in & ready_in;
  assign w_last_elem = (r_i == LAST_I) && (r_j == LAST_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD_A;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD_A:  if (w_beat && r_wcnt == LAST_W) w_next = S_LOAD_B;
      S_LOAD_B:  if (w_beat && r_wcnt == LAST_W) w_next = S_COMPUTE;
      S_COMPUTE: if (r_k == LAST_I) w_next = S_FLUSH;
      S_FLUSH:   w_next = S_OUT;
      S_OUT:     if (ready_out) w_next = w_last_elem ? S_LOAD_A : S_COMPUTE;
      default:   w_next = S_LOAD_A;
    endcase
  end

  always_comb begin
    ready_in  = 1'b0;
    wr_sel    = 1'b0;
    rd_en     = 1'b0;
    valid_out = 1'b0;
    last      = 1'b0;
    case (r_state)
      S_LOAD_A:  ready_in = 1'b1;
      S_LOAD_B:  begin ready_in = 1'b1; wr_sel = 1'b1; end
      S_COMPUTE: rd_en = 1'b1;
      S_OUT:     begin valid_out = 1'b1; last = w_last_elem; end
      default:   ;
    endcase
  end

  // i/j wrap back to 0 on the final handshake, so the next job starts clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt    <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc_en  <= 1'b0;
      r_acc_clr <= 1'b0;
    end else begin
      r_acc_en  <= rd_en;
      r_acc_clr <= rd_en & (r_k == '0);
      if (w_beat) r_wcnt <= (r_wcnt == LAST_W) ? '0 : r_wcnt + AW'(1);
      if (r_state == S_COMPUTE) r_k <= (r_k == LAST_I) ? '0 : r_k + IW'(1);
      if (r_state == S_OUT && ready_out) begin
        if (r_j == LAST_I) begin
          r_j <= '0;
          r_i <= (r_i == LAST_I) ? '0 : r_i + IW'(1);
        end else begin
          r_j <= r_j + IW'(1);
        end
      end
    end
  end

  assign wr_en     = w_beat;
  assign wr_addr   = r_wcnt;
  assign rd_addr_a = AW'(int'(r_i) * elementsNum + int'(r_k));
  assign rd_addr_b = AW'(int'(r_k) * elementsNum + int'(r_j));
  assign acc_en    = r_acc_en;
  assign acc_clr   = r_acc_clr;
  assign busy      = (r_state != S_LOAD_A) || (r_wcnt != '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: a cycle table for the N=2 main flow plus
// hand-written sequences for gapped loads, output stall, mid-run reset and N=1.
module tb_matmul_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       valid_in, ready_out;
  logic       ready_in, wr_en, wr_sel, rd_en, acc_en, acc_clr, valid_out, last, busy;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [2:0] dbg_state;

  logic       valid_in1, ready_out1;
  logic       ready_in1, wr_en1, wr_sel1, rd_en1, acc_en1, acc_clr1, valid_out1, last1, busy1;
  logic [0:0] wr_addr1, rd_addr_a1, rd_addr_b1;
  logic [2:0] dbg_state1;

  int total = 0;
  int bad   = 0;

  matmul_seq_ctrl #(.elementsNum(2), .dataWidth(16)) u_dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .acc_en(acc_en), .acc_clr(acc_clr), .ready_out(ready_out),
    .valid_out(valid_out), .last(last), .busy(busy), .dbg_state(dbg_state)
  );

  matmul_seq_ctrl #(.elementsNum(1), .dataWidth(16)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in1), .ready_in(ready_in1), .wr_en(wr_en1),
    .wr_sel(wr_sel1), .wr_addr(wr_addr1), .rd_en(rd_en1), .rd_addr_a(rd_addr_a1),
    .rd_addr_b(rd_addr_b1), .acc_en(acc_en1), .acc_clr(acc_clr1), .ready_out(ready_out1),
    .valid_out(valid_out1), .last(last1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vi, ro;
    logic       ri, we, ws;
    logic [1:0] wa;
    logic       re;
    logic [1:0] ra, rb;
    logic       ae, ac, vo, ls, bz;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic vi, ro, ri, we, ws, input logic [1:0] wa,
                              input logic re, input logic [1:0] ra, rb,
                              input logic ae, ac, vo, ls, bz);
    vec_t v;
    v.vi = vi; v.ro = ro; v.ri = ri; v.we = we; v.ws = ws; v.wa = wa; v.re = re;
    v.ra = ra; v.rb = rb; v.ae = ae; v.ac = ac; v.vo = vo; v.ls = ls; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vi, input logic ro);
    @(negedge clk);
    valid_in  = vi;
    ready_out = ro;
    #1;
  endtask

  task automatic drive1(input logic vi, input logic ro);
    @(negedge clk);
    valid_in1  = vi;
    ready_out1 = ro;
    #1;
  endtask

  task automatic run_table(input string tag);
    logic [14:0] got, exp;
    for (int n = 0; n < 25; n++) begin
      drive(tbl[n].vi, tbl[n].ro);
      got = {ready_in, wr_en, wr_sel, wr_addr, rd_en, rd_addr_a, rd_addr_b,
             acc_en, acc_clr, valid_out, last, busy};
      exp = {tbl[n].ri, tbl[n].we, tbl[n].ws, tbl[n].wa, tbl[n].re, tbl[n].ra, tbl[n].rb,
             tbl[n].ae, tbl[n].ac, tbl[n].vo, tbl[n].ls, tbl[n].bz};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s row %0d got=%b exp=%b (ri we ws wa re ra rb ae ac vo ls bz)",
                 tag, n, got, exp);
      end
    end
  endtask

  initial begin
    //            vi ro ri we ws wa re ra rb ae ac vo ls bz
    tbl[0]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 1, 1, 3, 1, 1, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 3, 2, 1, 1, 0, 0, 1);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 1);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 1, 0, 0, 0, 0, 1, 3, 3, 1, 1, 0, 0, 1);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1);
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 1);
    tbl[24] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b0; valid_in1 = 1'b0; ready_out1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_in", ready_in, 1);
    chk("rst_outputs", {wr_en, wr_sel, wr_addr, rd_en, rd_addr_a, rd_addr_b,
                        acc_en, acc_clr, valid_out, last, busy}, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;

    // tests 1 and 2: full-rate load and compute
    run_table("main");

    // test 4: one beat on, three off, during both loads
    for (int b = 0; b < 8; b++) begin
      drive(1, 0);
      chk("gap_beat_we", wr_en, 1);
      chk("gap_beat_wa", wr_addr, b % 4);
      chk("gap_beat_ws", wr_sel, b / 4);
      if (b < 7) begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 0);
          chk("gap_idle_we", wr_en, 0);
          chk("gap_idle_wa", wr_addr, (b + 1) % 4);
          chk("gap_idle_ri", ready_in, 1);
        end
      end
    end
    drive(0, 0);
    chk("gap_compute_entry_re", rd_en, 1);
    chk("gap_compute_entry_ri", ready_in, 0);

    // test 3: stall the output of C(0,1)
    drive(0, 0);
    drive(0, 0);
    drive(0, 1);
    chk("c00_vo", valid_out, 1);
    drive(0, 0);
    chk("c01_ra", rd_addr_a, 0);
    chk("c01_rb", rd_addr_b, 1);
    drive(0, 0);
    drive(0, 0);
    for (int s = 0; s < 5; s++) begin
      drive(0, 0);
      chk("stall_vo", valid_out, 1);
      chk("stall_re", rd_en, 0);
      chk("stall_ae", acc_en, 0);
      chk("stall_ls", last, 0);
    end
    drive(0, 1);
    chk("stall_release_vo", valid_out, 1);
    drive(0, 1);
    chk("c10_k0_re", rd_en, 1);
    chk("c10_k0_addr", {rd_addr_a, rd_addr_b}, {2'd2, 2'd0});
    drive(0, 1);
    chk("c10_k1_addr", {rd_addr_a, rd_addr_b}, {2'd3, 2'd2});
    chk("c10_k1_acc", {acc_en, acc_clr}, 2'b11);
    drive(0, 1);
    drive(0, 1);
    chk("c10_vo", {valid_out, last}, 2'b10);
    repeat (3) drive(0, 1);
    drive(0, 1);
    chk("c11_vo_last", {valid_out, last}, 2'b11);
    drive(0, 0);
    chk("back_to_load_a", {ready_in, busy}, 2'b10);

    // test 5: reset during COMPUTE of C(1,0)
    for (int b = 0; b < 8; b++) drive(1, 1);
    for (int c = 0; c < 8; c++) drive(0, 1);
    drive(0, 1);
    chk("pre_rst_c10_re", rd_en, 1);
    chk("pre_rst_c10_ra", rd_addr_a, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready_in", ready_in, 1);
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    run_table("after_reset");

    // test 6: N=1 instance
    drive1(1, 1);
    chk("n1_a_we", {wr_en1, wr_sel1, wr_addr1}, 3'b100);
    drive1(1, 1);
    chk("n1_b_we", {wr_en1, wr_sel1, wr_addr1}, 3'b110);
    drive1(0, 1);
    chk("n1_rd", {rd_en1, rd_addr_a1, rd_addr_b1, ready_in1}, 4'b1000);
    drive1(0, 1);
    chk("n1_flush_acc", {acc_en1, acc_clr1, valid_out1, rd_en1}, 4'b1100);
    drive1(0, 1);
    chk("n1_out", {valid_out1, last1, acc_en1}, 3'b110);
    drive1(0, 1);
    chk("n1_reload", {ready_in1, valid_out1, busy1}, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
